// File: rtl/jump_sequencer.sv
// rtl/jump_sequencer.sv - multi-cycle jump command sequencer with shared operand-fetch port
module jump_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd,
  output logic        fetch_req,
  output logic [3:0]  fetch_reg,
  input  logic        fetch_ack,
  input  logic [31:0] fetch_data,
  output logic [31:0] eval_cmd,
  output logic [31:0] eval_arg_1,
  output logic [31:0] eval_arg_2,
  input  logic        eval_should_jump,
  output logic        res_valid,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic        res_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A1,
    S_FETCH_A2,
    S_EVAL,
    S_FETCH_DEST,
    S_RESP
  } state_e;

  localparam logic [9:0] JUMP_OP      = 10'b0010000000;
  // Last counter value before a fetch gives up; an ack seen in that same cycle still wins.
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state;
  state_e      state_n;

  logic [3:0]  a1_code;
  logic [3:0]  a2_code;
  logic [3:0]  dest_code;
  logic        two_args;
  logic [7:0]  wait_cnt;

  logic        dec_is_jump;
  logic        dec_legal;
  logic [1:0]  dec_nargs;
  logic [3:0]  dec_a1;
  logic [3:0]  dec_a2;

  logic        in_fetch;
  logic        fetch_expired;
  logic        decline;

  // Decode the incoming command word: operand register codes and argument count per jump type.
  always_comb begin
    dec_is_jump = (cmd[31:22] == JUMP_OP);
    dec_legal   = 1'b1;
    dec_nargs   = 2'd0;
    dec_a1      = 4'd0;
    dec_a2      = 4'd0;
    case (cmd[21:19])
      3'b000: begin
        dec_nargs = 2'd0;
      end
      3'b001: begin
        dec_nargs = 2'd2;
        dec_a1    = cmd[10:7];
        dec_a2    = cmd[5:2];
      end
      3'b010: begin
        dec_nargs = 2'd2;
        dec_a1    = cmd[12:9];
        dec_a2    = cmd[7:4];
      end
      3'b011: begin
        dec_nargs = 2'd1;
        dec_a1    = cmd[6:3];
      end
      3'b100: begin
        dec_nargs = 2'd1;
        dec_a1    = cmd[9:6];
      end
      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  // Non-jump commands and illegal jump types skip straight to the response.
  assign decline = !dec_is_jump || !dec_legal;

  assign in_fetch      = (state == S_FETCH_A1) || (state == S_FETCH_A2) || (state == S_FETCH_DEST);
  assign fetch_expired = in_fetch && !fetch_ack && (wait_cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; fetch_ack only matters while a fetch is outstanding.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (decline) begin
            state_n = S_RESP;
          end else if (dec_nargs != 2'd0) begin
            state_n = S_FETCH_A1;
          end else begin
            state_n = S_EVAL;
          end
        end
      end
      S_FETCH_A1: begin
        if (fetch_ack) begin
          state_n = two_args ? S_FETCH_A2 : S_EVAL;
        end else if (fetch_expired) begin
          state_n = S_RESP;
        end
      end
      S_FETCH_A2: begin
        if (fetch_ack) begin
          state_n = S_EVAL;
        end else if (fetch_expired) begin
          state_n = S_RESP;
        end
      end
      S_EVAL: begin
        state_n = eval_should_jump ? S_FETCH_DEST : S_RESP;
      end
      S_FETCH_DEST: begin
        if (fetch_ack || fetch_expired) begin
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Handshake and fetch-port outputs decoded from the current state.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    res_valid = (state == S_RESP);
    fetch_req = in_fetch;
    fetch_reg = 4'd0;
    case (state)
      S_FETCH_A1:   fetch_reg = a1_code;
      S_FETCH_A2:   fetch_reg = a2_code;
      S_FETCH_DEST: fetch_reg = dest_code;
      default:      fetch_reg = 4'd0;
    endcase
  end

  // Datapath: latch command and operands, run the fetch wait counter, and set the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      eval_cmd   <= 32'd0;
      eval_arg_1 <= 32'd0;
      eval_arg_2 <= 32'd0;
      res_taken  <= 1'b0;
      res_error  <= 1'b0;
      res_target <= 32'd0;
      a1_code    <= 4'd0;
      a2_code    <= 4'd0;
      dest_code  <= 4'd0;
      two_args   <= 1'b0;
      wait_cnt   <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            eval_cmd   <= cmd;
            eval_arg_1 <= 32'd0;
            eval_arg_2 <= 32'd0;
            a1_code    <= dec_a1;
            a2_code    <= dec_a2;
            dest_code  <= cmd[17:14];
            two_args   <= (dec_nargs == 2'd2);
            wait_cnt   <= 8'd0;
            if (decline) begin
              res_taken <= 1'b0;
              res_error <= dec_is_jump;
            end
          end
        end
        S_FETCH_A1: begin
          if (fetch_ack) begin
            eval_arg_1 <= fetch_data;
            wait_cnt   <= 8'd0;
          end else if (fetch_expired) begin
            res_taken <= 1'b0;
            res_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_FETCH_A2: begin
          if (fetch_ack) begin
            eval_arg_2 <= fetch_data;
            wait_cnt   <= 8'd0;
          end else if (fetch_expired) begin
            res_taken <= 1'b0;
            res_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_EVAL: begin
          wait_cnt <= 8'd0;
          if (!eval_should_jump) begin
            res_taken <= 1'b0;
            res_error <= 1'b0;
          end
        end
        S_FETCH_DEST: begin
          if (fetch_ack) begin
            res_target <= fetch_data;
            res_taken  <= 1'b1;
            res_error  <= 1'b0;
          end else if (fetch_expired) begin
            res_taken <= 1'b0;
            res_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
